// File: rtl/serial_result_collector_pkg.sv
// Shared types and default sizing for the serial result collector.
package serial_result_collector_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 2;
  localparam int DEF_CNTW  = 8;

  // IDLE: waiting for the first bit of a frame
  // SHIFT: collecting serial bits, LSB first
  // PUSH: one-cycle hand-off of the finished word to the FIFO
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PUSH  = 2'd2
  } state_t;

  // Finished frame: {carry, bit[DEF_WIDTH-1:0]}
  typedef logic [DEF_WIDTH:0] frame_t;

endpackage

// File: rtl/serial_result_collector_sync_fifo.sv
// Small synchronous FIFO with occupancy count. The head entry is shown
// combinationally from the registered read pointer and reads as zero
// when empty. A push while full is accepted only together with a pop.
module sync_fifo
  import serial_result_collector_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int DW    = DEF_WIDTH + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [DW-1:0]                wdata_i,
  output logic [DW-1:0]                rdata_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full, do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign do_push = push_i & (~full | pop_i);
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; power-of-2 depth lets pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/serial_result_collector.sv
// Collects an LSB-first serial result plus final carry into a parallel
// word and queues finished words for a ready/valid consumer. Steps in
// lockstep with the upstream stage through the shared control qualifier.
module serial_result_collector
  import serial_result_collector_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNTW  = DEF_CNTW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             control,
  input  logic             s_bit,
  input  logic             c_in,
  output logic [WIDTH:0]   out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             drop,
  output logic [CNTW-1:0]  drop_cnt
);

  localparam int BCW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int CW  = $clog2(DEPTH + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

  state_t          state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic            carry_q, carry_d;
  logic [BCW-1:0]  bit_cnt_q, bit_cnt_d;
  logic            drop_q, drop_d;
  logic [CNTW-1:0] drop_cnt_q, drop_cnt_d;

  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_count;

  assign fifo_push = (state_q == PUSH);
  assign fifo_pop  = out_valid & out_ready;
  assign fifo_full = (fifo_count == CW'(DEPTH));

  assign out_valid = ~fifo_empty;
  assign busy      = (state_q == SHIFT) && (bit_cnt_q != '0);
  assign drop      = drop_q;
  assign drop_cnt  = drop_cnt_q;

  // Next-state: capture a bit on every qualified edge in IDLE/SHIFT; PUSH
  // never captures, it only hands the word over or drops it.
  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    carry_d    = carry_q;
    bit_cnt_d  = bit_cnt_q;
    drop_d     = 1'b0;
    drop_cnt_d = drop_cnt_q;
    case (state_q)
      IDLE, SHIFT: begin
        if (control) begin
          sreg_d = {s_bit, sreg_q[WIDTH-1:1]};
          if (bit_cnt_q == LAST_BIT) begin
            carry_d   = c_in;
            bit_cnt_d = '0;
            state_d   = PUSH;
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
            state_d   = SHIFT;
          end
        end
      end
      PUSH: begin
        if (fifo_full && !fifo_pop) begin
          drop_d = 1'b1;
          if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNTW'(1);
        end
        state_d = control ? SHIFT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, shift register and drop bookkeeping with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      sreg_q     <= '0;
      carry_q    <= 1'b0;
      bit_cnt_q  <= '0;
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      carry_q    <= carry_d;
      bit_cnt_q  <= bit_cnt_d;
      drop_q     <= drop_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .DW    (WIDTH + 1)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i ({carry_q, sreg_q}),
    .rdata_o (out_data),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

endmodule

// File: doc/serial_result_collector.md
Name: serial_result_collector

Overview:
- Downstream consumer of the 4-bit serial shift/add stage (ports A, B, in_B, control, reset, clk).
- Deserializes that stage's LSB-first serial result bit plus its final carry into a (WIDTH+1)-bit parallel word.
- Buffers finished words in a small FIFO and hands them out on a ready/valid interface to the next stage.
- Shares the upstream `control` qualifier so both stages step in lockstep.

Parameters:
- WIDTH, 4, serial frame length in bits (matches upstream operand width).
- DEPTH, 2, output FIFO entries (power of 2, ≥2).
- CNTW, 8, width of the dropped-frame counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- control  input  1  upstream step enable; a serial bit is valid on every clk edge where control=1.
- s_bit  input  1  serial result bit from upstream, LSB first.
- c_in  input  1  upstream carry/MSB, sampled with the last bit of a frame.
- out_data  output  WIDTH+1  collected word, {carry, bit[WIDTH-1:0]}.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts out_data this cycle.
- busy  output  1  frame partially collected (bit_cnt≠0).
- drop  output  1  one-cycle pulse: completed frame discarded because the FIFO was full.
- drop_cnt  output  CNTW  saturating count of dropped frames.

Behaviour:
- Reset (reset=0 at a clk edge):
  - FSM state=IDLE; shift reg, bit_cnt, FIFO pointers and count, drop and drop_cnt all 0.
  - out_valid=0, busy=0, out_data=0.
  - Reset mid-frame discards the partial frame. Reset overrides every other input.
- FSM states:
  - IDLE→SHIFT on control=1. The bit presented on that same edge is captured as bit 0.
  - SHIFT, control=1:
    - sreg <= {s_bit, sreg[WIDTH-1:1]}; bit_cnt++.
    - On the capture where bit_cnt==WIDTH-1, also latch c_in into the carry bit, clear bit_cnt, and go to PUSH.
  - SHIFT, control=0: stall. Hold sreg and bit_cnt; no timeout.
  - PUSH (one cycle):
    - Write {carry, sreg} into the FIFO if not full, or if full and a pop occurs this same cycle.
    - Otherwise discard the word, pulse drop=1, and increment drop_cnt (saturates at all-ones).
    - PUSH→SHIFT if control=1, else →IDLE. No serial bit is captured during PUSH; upstream must pause control one cycle per frame. A control=1 in PUSH begins the next frame on the following edge.
- Latency: a word is visible on out_data/out_valid 2 edges after the final bit's capture edge (capture→PUSH, PUSH→FIFO write).
- FIFO:
  - out_data = head entry, registered-pointer read; out_data=0 when empty.
  - Pop on out_valid & out_ready.
  - Push and pop in the same cycle are both honoured when full and when empty-with-pop-ignored (empty: pop is a no-op).
  - Pointers wrap modulo DEPTH; count tracks 0..DEPTH.
- Arithmetic: no arithmetic on data; bit order is strictly LSB first.
- busy=1 while in SHIFT with bit_cnt≠0.

Decomposition:
- Shared package: FSM state enum (IDLE, SHIFT, PUSH), default WIDTH/DEPTH constants, and the frame-word typedef of WIDTH+1 bits.
- One sub-module is natural: `sync_fifo` (parameter DEPTH and data width; push/pop/full/empty/count), reusable elsewhere.
- Collector FSM and shift register stay in the top module.

Test Plan:
- Reset then basic frame:
  - Stimulus: hold reset=0 for 2 clk, release. control=1 for 4 clk with s_bit=0,0,1,1 (LSB first) and c_in=0 on the 4th bit; out_ready=1.
  - Required: out_valid=1 for exactly 1 cycle, 2 edges after the last bit, out_data=5'b01100 (0101+0111). busy=1 during bits 2-4.
- Stall mid-frame:
  - Stimulus: 2 bits, then control=0 for 3 clk, then 2 more bits forming 1011 with c_in=1.
  - Required: bit_cnt held during the stall; out_data=5'b11011.
- Backpressure and overflow:
  - Stimulus: out_ready=0; send 3 frames (1111, 0001, 0010, carry 0).
  - Required: FIFO holds 01111, 00001; 3rd frame gives drop=1 pulse and drop_cnt=1. Raising out_ready pops 01111 then 00001, then out_valid=0.
- Simultaneous push/pop when full:
  - Stimulus: FIFO full, out_ready=1 in the PUSH cycle.
  - Required: no drop; head pops; new word becomes the 2nd entry; count stays 2.
- Reset mid-frame:
  - Stimulus: reset=0 after 2 bits of a frame.
  - Required: busy=0, out_valid=0, FIFO empty, drop_cnt=0 next edge. A following clean frame 0101 gives out_data=5'b00101.
- Back-to-back frames:
  - Stimulus: control held 1 continuously.
  - Required: a frame is collected every WIDTH+1 edges; the PUSH-cycle bit is ignored.
